// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- bus-attached 8N1 UART receiver with a small receive FIFO.
//
// The serial line is double-flopped and oversampled with a down-counter that
// places each sample near the middle of a bit. Completed bytes go into a
// circular FIFO. The FIFO head and the status flags are readable through the
// single-cycle device bus.
//
// Register map (word offsets, decoded from device_addr_i[3:2]):
//   0x0 RXDATA  read : {24'b0, head}; the read pops the FIFO (0 if empty)
//   0x4 STATUS  read : [0] not_empty [1] full [2] overflow [3] frame_err
//                      [15:8] count
//   0x8 CLEAR   write: wdata[2] clears overflow, wdata[3] clears frame_err
//   Other accesses are ignored and return 0.
//
// Bus handshake: every cycle with device_req_i high is one request. Exactly
// one cycle later device_rvalid_o is high for one cycle and device_rdata_o
// carries the response (0 for writes). There is no back-pressure, so a
// request may be issued every cycle.
//
// Ports:
//   clk_i, rst_i          system clock, asynchronous active-high reset
//   device_req_i          bus request (one cycle per access)
//   device_addr_i         byte address, bits [3:2] decoded
//   device_we_i           write enable
//   device_be_i           byte enables (unused, whole-word registers)
//   device_wdata_i        write data
//   device_rvalid_o       response valid, one cycle after each request
//   device_rdata_o        registered read data
//   uart_rx_i             asynchronous serial input, idle high
//   rx_irq_o              high while the FIFO holds data (registered)
// ---------------------------------------------------------------------------
module uart_rx #(
   parameter int ClockFrequency = 50_000_000,
   parameter int BaudRate       = 115_200,
   parameter int FifoDepth      = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        device_req_i,
   input  logic [31:0] device_addr_i,
   input  logic        device_we_i,
   input  logic [3:0]  device_be_i,
   input  logic [31:0] device_wdata_i,
   output logic        device_rvalid_o,
   output logic [31:0] device_rdata_o,
   input  logic        uart_rx_i,
   output logic        rx_irq_o
);

   localparam int ClksPerBit = ClockFrequency / BaudRate;
   localparam int CntW       = $clog2(ClksPerBit);
   localparam int PtrW       = $clog2(FifoDepth);

   localparam logic [CntW-1:0] HalfLoad  = CntW'(ClksPerBit / 2 - 1);
   localparam logic [CntW-1:0] BitLoad   = CntW'(ClksPerBit - 1);
   localparam logic [CntW-1:0] CntOne    = CntW'(1);
   localparam logic [PtrW:0]   FullCount = (PtrW + 1)'(FifoDepth);
   localparam logic [PtrW:0]   CountOne  = (PtrW + 1)'(1);
   localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   // ------------------------------------------------------------------
   // Input synchroniser and start-bit arming
   // ------------------------------------------------------------------
   logic [1:0] sync_q;
   logic       rx_s;
   logic [1:0] settle_q;
   logic       armed_q;

   assign rx_s = sync_q[1];

   // The synchroniser flops come out of reset at 1, so a line that is
   // already low would look like a fresh falling edge two cycles later.
   // settle_q marks when rx_s reflects the real line; the receiver is only
   // armed once it has seen the line high after that point.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q   <= 2'b11;
         settle_q <= 2'b00;
         armed_q  <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], uart_rx_i};
         settle_q <= {settle_q[0], 1'b1};
         armed_q  <= armed_q | (settle_q[1] & rx_s);
      end
   end

   // ------------------------------------------------------------------
   // Receive FSM
   // ------------------------------------------------------------------
   state_t          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            rx_push;
   logic            ferr_set;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      rx_push  = 1'b0;
      ferr_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (armed_q && !rx_s) begin
               cnt_d   = HalfLoad;
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == '0) begin
               if (rx_s) begin
                  // Line went back high before mid start bit: glitch.
                  state_d = IDLE;
               end else begin
                  cnt_d   = BitLoad;
                  idx_d   = '0;
                  state_d = DATA;
               end
            end else begin
               cnt_d = cnt_q - CntOne;
            end
         end
         DATA: begin
            if (cnt_q == '0) begin
               shift_d[idx_q] = rx_s;
               cnt_d          = BitLoad;
               if (idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - CntOne;
            end
         end
         STOP: begin
            if (cnt_q == '0) begin
               if (rx_s) begin
                  rx_push = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_set = 1'b1;
                  state_d  = WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q - CntOne;
            end
         end
         WAIT_HIGH: begin
            // Hold off until a break ends so it is not taken as a start bit.
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic [1:0] reg_sel;
   logic       rd_req;
   logic       wr_req;

   assign reg_sel = device_addr_i[3:2];
   assign rd_req  = device_req_i & ~device_we_i;
   assign wr_req  = device_req_i & device_we_i;

   // ------------------------------------------------------------------
   // Receive FIFO
   // ------------------------------------------------------------------
   logic [7:0]      mem [FifoDepth];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]   count_q;
   logic            fifo_empty, fifo_full;
   logic            do_pop, do_push, ovf_set;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FullCount);
   assign do_pop     = rd_req && (reg_sel == 2'd0) && !fifo_empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO
   // still succeeds then.
   assign do_push    = rx_push && (!fifo_full || do_pop);
   assign ovf_set    = rx_push && fifo_full && !do_pop;

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_ptr_q] <= shift_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PtrOne;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PtrOne;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CountOne;
            2'b01:   count_q <= count_q - CountOne;
            default: count_q <= count_q;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Sticky flags; a set event wins over a clear in the same cycle
   // ------------------------------------------------------------------
   logic ovf_q, ferr_q;
   logic clr_ovf, clr_ferr;

   assign clr_ovf  = wr_req && (reg_sel == 2'd2) && device_wdata_i[2];
   assign clr_ferr = wr_req && (reg_sel == 2'd2) && device_wdata_i[3];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovf_q  <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         if (ovf_set) begin
            ovf_q <= 1'b1;
         end else if (clr_ovf) begin
            ovf_q <= 1'b0;
         end
         if (ferr_set) begin
            ferr_q <= 1'b1;
         end else if (clr_ferr) begin
            ferr_q <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Read data and response registers
   // ------------------------------------------------------------------
   logic [7:0]  count_ext;
   logic [31:0] rdata_d;
   logic        rvalid_q;
   logic [31:0] rdata_q;
   logic        irq_q;

   assign count_ext = 8'(count_q);

   always_comb begin
      rdata_d = '0;
      if (rd_req) begin
         case (reg_sel)
            2'd0: begin
               if (!fifo_empty) begin
                  rdata_d = {24'b0, mem[rd_ptr_q]};
               end
            end
            2'd1: begin
               rdata_d = {16'b0, count_ext, 4'b0, ferr_q, ovf_q, fifo_full, !fifo_empty};
            end
            default: begin
               rdata_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         irq_q    <= 1'b0;
      end else begin
         rvalid_q <= device_req_i;
         rdata_q  <= rdata_d;
         irq_q    <= !fifo_empty;
      end
   end

   assign device_rvalid_o = rvalid_q;
   assign device_rdata_o  = rdata_q;
   assign rx_irq_o        = irq_q;

   // Address/data bits outside the decoded fields and the byte enables
   // carry no meaning for this block.
   logic unused_bits;
   assign unused_bits = ^{device_be_i, device_addr_i[31:4], device_addr_i[1:0],
                          device_wdata_i[31:4], device_wdata_i[1:0]};

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx.
//
// The serial driver generates 8N1 frames; a queue-based model of the
// receiver (byte queue plus two sticky flags) predicts every bus response.
// Each bus request pushes its predicted rdata into exp_q; a monitor pops and
// compares whenever device_rvalid_o is seen.
// A reduced bit period keeps the run short.
// ---------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CLK_FREQ  = 3_686_400;
   localparam int BAUD      = 115_200;
   localparam int CPB       = CLK_FREQ / BAUD;     // 32 clocks per bit
   localparam int DEPTH     = 8;
   // Clock edge (counted from the edge that launches the start bit) at which
   // the receiver samples the stop bit: 2 synchroniser edges, 1 edge to
   // enter START, CPB/2 edges to mid start bit, then 9 full bit periods.
   localparam int STOP_EDGE = 3 + CPB / 2 + 9 * CPB;
   localparam int GLITCH    = CPB / 4;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        rvalid;
   logic [31:0] rdata;
   logic        line;
   logic        irq;

   always #5 clk = ~clk;

   uart_rx #(
      .ClockFrequency(CLK_FREQ),
      .BaudRate      (BAUD),
      .FifoDepth     (DEPTH)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .device_req_i   (req),
      .device_addr_i  (addr),
      .device_we_i    (we),
      .device_be_i    (be),
      .device_wdata_i (wdata),
      .device_rvalid_o(rvalid),
      .device_rdata_o (rdata),
      .uart_rx_i      (line),
      .rx_irq_o       (irq)
   );

   // ---------------- reference model ----------------
   logic [7:0]  model_q[$];
   logic        m_ovf;
   logic        m_ferr;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   int checks   = 0;
   int failures = 0;

   function automatic logic [31:0] model_status();
      logic [7:0] cnt;
      cnt = 8'(model_q.size());
      return {16'b0, cnt, 4'b0, m_ferr, m_ovf, model_q.size() == DEPTH, model_q.size() != 0};
   endfunction

   task automatic model_rx(input logic [7:0] b);
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else m_ovf = 1'b1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One 8N1 frame. The line is left at the stop-bit level, so a stop of 0
   // continues as a break until the caller releases it.
   task automatic send_byte(input logic [7:0] b, input logic stop, input logic to_model);
      @(posedge clk);
      #1 line = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 line = b[i];
         repeat (CPB) @(posedge clk);
      end
      #1 line = stop;
      repeat (CPB) @(posedge clk);
      #1;
      if (to_model) begin
         if (stop) model_rx(b);
         else m_ferr = 1'b1;
      end
   endtask

   // Issues one bus access (called just after a rising edge) and records the
   // response the model predicts.
   task automatic bus_op(input logic w, input logic [1:0] off, input logic [31:0] d,
                         input string tag);
      logic [31:0] e;
      e = '0;
      if (!w) begin
         if (off == 2'd0) begin
            if (model_q.size() > 0) e = {24'b0, model_q.pop_front()};
         end else if (off == 2'd1) begin
            e = model_status();
         end
      end else if (off == 2'd2) begin
         if (d[2]) m_ovf = 1'b0;
         if (d[3]) m_ferr = 1'b0;
      end
      exp_q.push_back(e);
      tag_q.push_back(tag);
      req   = 1'b1;
      we    = w;
      addr  = ($urandom() & 32'hFFFF_FFF0) | {28'b0, off, 2'b00};
      be    = 4'($urandom_range(0, 15));
      wdata = d;
      @(posedge clk);
      #1;
      req = 1'b0;
      we  = 1'b0;
   endtask

   task automatic check_irq(input string name);
      idle(2);
      check(name, {31'b0, irq}, {31'b0, model_q.size() != 0});
   endtask

   // ---------------- scoreboard monitor ----------------
   logic [31:0] mon_exp;
   string       mon_tag;

   always @(negedge clk) begin
      if (!rst && rvalid) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_rvalid actual=1 required=0 rdata=0x%08h", rdata);
         end else begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            if (rdata !== mon_exp) begin
               failures++;
               $display("FAIL %s actual=0x%08h required=0x%08h", mon_tag, rdata, mon_exp);
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench did not finish");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] b;
      rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0; line = 1'b1;
      m_ovf = 1'b0; m_ferr = 1'b0;
      idle(3);
      check("reset_rvalid", {31'b0, rvalid}, 32'd0);
      check("reset_rdata", rdata, 32'd0);
      check("reset_irq", {31'b0, irq}, 32'd0);
      rst = 1'b0;
      idle(4);
      bus_op(1'b0, 2'd1, '0, "status_after_reset");

      // Single byte.
      send_byte(8'hA5, 1'b1, 1'b1);
      check_irq("irq_one_byte");
      bus_op(1'b0, 2'd1, '0, "status_one_byte");
      bus_op(1'b0, 2'd0, '0, "rxdata_a5");
      bus_op(1'b0, 2'd1, '0, "status_drained");
      check_irq("irq_drained");

      // Overflow: nine bytes, no reads.
      for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1, 1'b1);
      bus_op(1'b0, 2'd1, '0, "status_overflow");
      for (int i = 0; i < 8; i++) bus_op(1'b0, 2'd0, '0, "rxdata_ovf_seq");
      bus_op(1'b0, 2'd0, '0, "rxdata_empty");
      bus_op(1'b1, 2'd2, 32'h4, "clear_ovf_write");
      bus_op(1'b0, 2'd1, '0, "status_ovf_cleared");

      // Short low glitch on an idle line, then a normal byte.
      line = 1'b0;
      idle(GLITCH);
      line = 1'b1;
      idle(2 * CPB);
      bus_op(1'b0, 2'd1, '0, "status_after_glitch");
      send_byte(8'h7E, 1'b1, 1'b1);
      bus_op(1'b0, 2'd0, '0, "rxdata_after_glitch");

      // Framing error followed by a break of two bit times.
      send_byte(8'h3C, 1'b0, 1'b1);
      idle(2 * CPB);
      line = 1'b1;
      idle(3 * CPB);
      bus_op(1'b0, 2'd1, '0, "status_frame_err");
      send_byte(8'h3C, 1'b1, 1'b1);
      bus_op(1'b0, 2'd1, '0, "status_ferr_plus_byte");
      bus_op(1'b0, 2'd0, '0, "rxdata_after_ferr");
      bus_op(1'b1, 2'd2, 32'h8, "clear_ferr_write");
      bus_op(1'b0, 2'd1, '0, "status_ferr_cleared");

      // Full FIFO, RXDATA read in the same cycle as the stop-bit sample.
      for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b1);
      bus_op(1'b0, 2'd1, '0, "status_full");
      b = 8'($urandom_range(0, 255));
      fork
         send_byte(b, 1'b1, 1'b1);
         begin
            @(posedge clk);
            repeat (STOP_EDGE - 1) @(posedge clk);
            #1;
            bus_op(1'b0, 2'd0, '0, "rxdata_at_stop_sample");
         end
      join
      bus_op(1'b0, 2'd1, '0, "status_full_no_ovf");
      for (int i = 0; i < DEPTH; i++) bus_op(1'b0, 2'd0, '0, "rxdata_order_kept");

      // Randomised traffic mixed with register accesses.
      for (int it = 0; it < 6; it++) begin
         int nb;
         int nops;
         nb = $urandom_range(0, 3);
         for (int k = 0; k < nb; k++) send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b1);
         check_irq("irq_random");
         nops = $urandom_range(1, 4);
         for (int k = 0; k < nops; k++) begin
            case ($urandom_range(0, 4))
               0, 1: bus_op(1'b0, 2'd0, '0, "rand_rxdata");
               2:    bus_op(1'b0, 2'd1, '0, "rand_status");
               3:    bus_op(1'b0, 2'd3, '0, "rand_read_unmapped");
               default: bus_op(1'b1, 2'($urandom_range(0, 2)), $urandom(), "rand_write");
            endcase
         end
         bus_op(1'b0, 2'd1, '0, "rand_status_end");
      end
      while (model_q.size() > 0) bus_op(1'b0, 2'd0, '0, "rand_drain");
      bus_op(1'b1, 2'd2, 32'hC, "rand_clear_all");

      // Reset in the middle of a frame's data bits with the line held low.
      send_byte(8'h11, 1'b1, 1'b1);
      check_irq("irq_before_reset");
      fork
         send_byte(8'h00, 1'b1, 1'b0);
         begin
            repeat (3 * CPB + CPB / 2) @(posedge clk);
            #1 rst = 1'b1;
            model_q.delete();
            m_ovf  = 1'b0;
            m_ferr = 1'b0;
            #1;
            check("midreset_rvalid", {31'b0, rvalid}, 32'd0);
            check("midreset_rdata", rdata, 32'd0);
            check("midreset_irq", {31'b0, irq}, 32'd0);
            @(posedge clk);
            #1 rst = 1'b0;
         end
      join
      idle(2 * CPB);
      bus_op(1'b0, 2'd1, '0, "status_after_midreset");
      send_byte(8'h5A, 1'b1, 1'b1);
      bus_op(1'b0, 2'd1, '0, "status_5a");
      bus_op(1'b0, 2'd0, '0, "rxdata_5a");
      check_irq("irq_final");

      idle(5);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
